// File: rtl/mesh_resp_pkg.sv
// Shared types and constants for the mesh DMA responder scratchpad.
package mesh_resp_pkg;

    localparam logic [31:0] RESP_ERR_WORD = 32'hDEAD_BEEF;

    typedef enum logic {
        NET = 1'b0,
        LCL = 1'b1
    } resp_port_e;

endpackage

// File: rtl/mesh_resp_rr_arb.sv
// Two-requester round-robin arbiter (network vs local) for the shared scratchpad.
// Grants are combinational; last_r remembers the most recent winner.
module mesh_resp_rr_arb
    import mesh_resp_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       net_v_i,
    input  logic       lcl_v_i,
    output logic       net_gnt_o,
    output logic       lcl_gnt_o,
    output resp_port_e last_o
);

    resp_port_e last_r;

    // On a tie the port that did not win last time goes first.
    always_comb begin
        net_gnt_o = 1'b0;
        lcl_gnt_o = 1'b0;
        if (!reset_i) begin
            if (net_v_i && (!lcl_v_i || last_r == LCL)) begin
                net_gnt_o = 1'b1;
            end else if (lcl_v_i) begin
                lcl_gnt_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            last_r <= LCL;
        end else if (net_gnt_o) begin
            last_r <= NET;
        end else if (lcl_gnt_o) begin
            last_r <= LCL;
        end
    end

    assign last_o = last_r;

endmodule

// File: rtl/mesh_dma_responder.sv
// Responder-side scratchpad shared by the mesh endpoint and a local port.
// Optional macro MESH_RESP_BOUNDS_CHECK_EN enables out-of-range detection and err_o.
module mesh_dma_responder
    import mesh_resp_pkg::*;
#(
    parameter int data_width_p = 32,
    parameter int addr_width_p = 10,
    parameter int mem_els_p    = 1024
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      in_v_i,
    output logic                      in_yumi_o,
    input  logic                      in_we_i,
    input  logic [addr_width_p-1:0]   in_addr_i,
    input  logic [data_width_p-1:0]   in_data_i,
    input  logic [data_width_p/8-1:0] in_mask_i,
    output logic                      returning_v_o,
    output logic [data_width_p-1:0]   returning_data_o,
    input  logic                      lcl_v_i,
    input  logic                      lcl_we_i,
    input  logic [addr_width_p-1:0]   lcl_addr_i,
    input  logic [data_width_p-1:0]   lcl_data_i,
    input  logic [data_width_p/8-1:0] lcl_mask_i,
    output logic                      lcl_yumi_o,
    output logic                      lcl_rvalid_o,
    output logic [data_width_p-1:0]   lcl_rdata_o,
    output logic                      err_o,
    output logic                      dbg_last_o
);

    localparam int mask_w_lp = data_width_p / 8;
    localparam int idx_w_lp  = (mem_els_p > 1) ? $clog2(mem_els_p) : 1;
    localparam int depth_lp  = 1 << idx_w_lp;
    localparam logic [data_width_p-1:0] err_word_lp = data_width_p'(RESP_ERR_WORD);

    logic                    net_gnt, lcl_gnt, gnt, oob;
    resp_port_e              last;
    logic                    sel_we;
    logic [addr_width_p-1:0] sel_addr;
    logic [data_width_p-1:0] sel_data, rd_word;
    logic [mask_w_lp-1:0]    sel_mask;
    logic [idx_w_lp-1:0]     idx;

    logic                    rd_pending_r;
    resp_port_e              rd_port_r;
    logic [data_width_p-1:0] net_rdata_r, lcl_rdata_r;

    mesh_resp_rr_arb u_arb (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .net_v_i   (in_v_i),
        .lcl_v_i   (lcl_v_i),
        .net_gnt_o (net_gnt),
        .lcl_gnt_o (lcl_gnt),
        .last_o    (last)
    );

    assign in_yumi_o  = net_gnt;
    assign lcl_yumi_o = lcl_gnt;
    assign gnt        = net_gnt | lcl_gnt;
    assign dbg_last_o = last;

    assign sel_we   = net_gnt ? in_we_i   : lcl_we_i;
    assign sel_addr = net_gnt ? in_addr_i : lcl_addr_i;
    assign sel_data = net_gnt ? in_data_i : lcl_data_i;
    assign sel_mask = net_gnt ? in_mask_i : lcl_mask_i;
    assign idx      = sel_addr[idx_w_lp-1:0];

`ifdef MESH_RESP_BOUNDS_CHECK_EN
    localparam logic [addr_width_p:0] els_lp = (addr_width_p + 1)'(mem_els_p);
    logic err_r;

    assign oob = ({1'b0, sel_addr} >= els_lp);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            err_r <= 1'b0;
        end else if (gnt && oob) begin
            err_r <= 1'b1;
        end
    end

    assign err_o = err_r;
`else
    assign oob   = 1'b0;
    assign err_o = 1'b0;
`endif

    // Depth rounded up to a power of two so a wrapped index never falls outside the array.
    logic [data_width_p-1:0] mem [depth_lp];

    always_ff @(posedge clk_i) begin
        if (gnt && sel_we && !oob) begin
            for (int b = 0; b < mask_w_lp; b++) begin
                if (sel_mask[b]) begin
                    mem[idx][8*b +: 8] <= sel_data[8*b +: 8];
                end
            end
        end
    end

    assign rd_word = oob ? err_word_lp : mem[idx];

    // Return registers only load on a load grant, so they hold between pulses.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_pending_r <= 1'b0;
            rd_port_r    <= NET;
            net_rdata_r  <= '0;
            lcl_rdata_r  <= '0;
        end else begin
            rd_pending_r <= gnt && !sel_we;
            if (gnt && !sel_we) begin
                rd_port_r <= net_gnt ? NET : LCL;
                if (net_gnt) begin
                    net_rdata_r <= rd_word;
                end else begin
                    lcl_rdata_r <= rd_word;
                end
            end
        end
    end

    assign returning_v_o    = rd_pending_r && (rd_port_r == NET);
    assign lcl_rvalid_o     = rd_pending_r && (rd_port_r == LCL);
    assign returning_data_o = net_rdata_r;
    assign lcl_rdata_o      = lcl_rdata_r;

endmodule

// File: tb/tb_mesh_dma_responder.sv
// Directed bench for mesh_dma_responder: driver pushes expected grants/returns,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_mesh_dma_responder;

    typedef struct packed {
        logic        v;
        logic        we;
        logic [9:0]  addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } req_t;

`ifdef MESH_RESP_BOUNDS_CHECK_EN
    localparam logic [31:0] exp_oob_word = 32'hDEAD_BEEF;
    localparam logic [31:0] exp_err      = 32'd1;
`else
    localparam logic [31:0] exp_oob_word = 32'h1234_5678;
    localparam logic [31:0] exp_err      = 32'd0;
`endif

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        in_v_i, in_we_i, in_yumi_o, returning_v_o;
    logic [9:0]  in_addr_i;
    logic [31:0] in_data_i, returning_data_o;
    logic [3:0]  in_mask_i;
    logic        lcl_v_i, lcl_we_i, lcl_yumi_o, lcl_rvalid_o;
    logic [9:0]  lcl_addr_i;
    logic [31:0] lcl_data_i, lcl_rdata_o;
    logic [3:0]  lcl_mask_i;
    logic        err_o, dbg_last_o;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    logic [1:0]  yumi_q[$];
    logic [31:0] net_exp_q[$];
    int          net_cyc_q[$];
    logic [31:0] lcl_exp_q[$];
    int          lcl_cyc_q[$];

    mesh_dma_responder #(
        .data_width_p (32),
        .addr_width_p (10),
        .mem_els_p    (1000)
    ) dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .in_v_i           (in_v_i),
        .in_yumi_o        (in_yumi_o),
        .in_we_i          (in_we_i),
        .in_addr_i        (in_addr_i),
        .in_data_i        (in_data_i),
        .in_mask_i        (in_mask_i),
        .returning_v_o    (returning_v_o),
        .returning_data_o (returning_data_o),
        .lcl_v_i          (lcl_v_i),
        .lcl_we_i         (lcl_we_i),
        .lcl_addr_i       (lcl_addr_i),
        .lcl_data_i       (lcl_data_i),
        .lcl_mask_i       (lcl_mask_i),
        .lcl_yumi_o       (lcl_yumi_o),
        .lcl_rvalid_o     (lcl_rvalid_o),
        .lcl_rdata_o      (lcl_rdata_o),
        .err_o            (err_o),
        .dbg_last_o       (dbg_last_o)
    );

    // Clock and cycle counter
    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic req_t nop();
        nop = '{v: 1'b0, we: 1'b0, addr: 10'd0, data: 32'd0, mask: 4'd0};
    endfunction

    function automatic req_t ld(input logic [9:0] a);
        ld = '{v: 1'b1, we: 1'b0, addr: a, data: 32'd0, mask: 4'd0};
    endfunction

    function automatic req_t st(input logic [9:0] a, input logic [31:0] d, input logic [3:0] m);
        st = '{v: 1'b1, we: 1'b1, addr: a, data: d, mask: m};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Driver: one request cycle; ey = {net_yumi, lcl_yumi} expected this cycle.
    task automatic cycle(input req_t n, input req_t l, input logic rst, input logic [1:0] ey,
                         input logic [31:0] en, input logic [31:0] el);
        @(posedge clk_i);
        #1;
        reset_i = rst;
        if (rst) begin
            // reset kills any return that would have shown up this cycle
            while (net_cyc_q.size() > 0 && net_cyc_q[$] >= cyc) begin
                void'(net_exp_q.pop_back());
                void'(net_cyc_q.pop_back());
            end
            while (lcl_cyc_q.size() > 0 && lcl_cyc_q[$] >= cyc) begin
                void'(lcl_exp_q.pop_back());
                void'(lcl_cyc_q.pop_back());
            end
        end
        in_v_i = n.v;  in_we_i = n.we;  in_addr_i = n.addr;  in_data_i = n.data;  in_mask_i = n.mask;
        lcl_v_i = l.v; lcl_we_i = l.we; lcl_addr_i = l.addr; lcl_data_i = l.data; lcl_mask_i = l.mask;
        yumi_q.push_back(ey);
        if (ey[1] && !n.we) begin
            net_exp_q.push_back(en);
            net_cyc_q.push_back(cyc + 1);
        end
        if (ey[0] && !l.we) begin
            lcl_exp_q.push_back(el);
            lcl_cyc_q.push_back(cyc + 1);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(nop(), nop(), 1'b0, 2'b00, 32'd0, 32'd0);
    endtask

    // Monitor / scoreboard
    always @(negedge clk_i) begin
        logic [1:0]  y;
        logic [31:0] e;
        int          c;
        if (yumi_q.size() > 0) begin
            y = yumi_q.pop_front();
            tests++;
            if ({in_yumi_o, lcl_yumi_o} !== y) begin
                failed++;
                $display("FAIL yumi: got {net,lcl}=%b expected %b (cycle %0d)",
                         {in_yumi_o, lcl_yumi_o}, y, cyc);
            end
        end
        if (returning_v_o === 1'b1) begin
            tests++;
            if (net_exp_q.size() == 0) begin
                failed++;
                $display("FAIL net_ret: unexpected pulse data %h (cycle %0d)", returning_data_o, cyc);
            end else begin
                e = net_exp_q.pop_front();
                c = net_cyc_q.pop_front();
                if (returning_data_o !== e || c != cyc) begin
                    failed++;
                    $display("FAIL net_ret: got %h at cycle %0d expected %h at cycle %0d",
                             returning_data_o, cyc, e, c);
                end
            end
        end else if (net_cyc_q.size() > 0 && net_cyc_q[0] <= cyc) begin
            tests++;
            failed++;
            $display("FAIL net_ret: missing, got no pulse expected %h (cycle %0d)", net_exp_q[0], cyc);
            void'(net_exp_q.pop_front());
            void'(net_cyc_q.pop_front());
        end
        if (lcl_rvalid_o === 1'b1) begin
            tests++;
            if (lcl_exp_q.size() == 0) begin
                failed++;
                $display("FAIL lcl_ret: unexpected pulse data %h (cycle %0d)", lcl_rdata_o, cyc);
            end else begin
                e = lcl_exp_q.pop_front();
                c = lcl_cyc_q.pop_front();
                if (lcl_rdata_o !== e || c != cyc) begin
                    failed++;
                    $display("FAIL lcl_ret: got %h at cycle %0d expected %h at cycle %0d",
                             lcl_rdata_o, cyc, e, c);
                end
            end
        end else if (lcl_cyc_q.size() > 0 && lcl_cyc_q[0] <= cyc) begin
            tests++;
            failed++;
            $display("FAIL lcl_ret: missing, got no pulse expected %h (cycle %0d)", lcl_exp_q[0], cyc);
            void'(lcl_exp_q.pop_front());
            void'(lcl_cyc_q.pop_front());
        end
    end

    initial begin
        reset_i = 1'b1;
        in_v_i = 1'b0;  in_we_i = 1'b0;  in_addr_i = '0;  in_data_i = '0;  in_mask_i = '0;
        lcl_v_i = 1'b0; lcl_we_i = 1'b0; lcl_addr_i = '0; lcl_data_i = '0; lcl_mask_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        in_v_i  = 1'b1;
        lcl_v_i = 1'b1;
        #1;
        chk("rst_in_yumi", {31'd0, in_yumi_o}, 32'd0);
        chk("rst_lcl_yumi", {31'd0, lcl_yumi_o}, 32'd0);
        chk("rst_ret_v", {31'd0, returning_v_o}, 32'd0);
        chk("rst_lcl_rvalid", {31'd0, lcl_rvalid_o}, 32'd0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
        chk("rst_ret_data", returning_data_o, 32'd0);
        chk("rst_lcl_rdata", lcl_rdata_o, 32'd0);
        chk("rst_last", {31'd0, dbg_last_o}, 32'd1);

        idle(1);
        // basic store/load, plus addr 0 seeded for the bounds test
        cycle(st(10'd0, 32'h0000_0A0A, 4'hF), nop(), 1'b0, 2'b10, 32'd0, 32'd0);
        cycle(st(10'd5, 32'hA5A5_1234, 4'hF), nop(), 1'b0, 2'b10, 32'd0, 32'd0);
        cycle(ld(10'd5), nop(), 1'b0, 2'b10, 32'hA5A5_1234, 32'd0);
        idle(1);
        // partial byte mask
        cycle(st(10'd7, 32'hFFFF_FFFF, 4'hF), nop(), 1'b0, 2'b10, 32'd0, 32'd0);
        cycle(st(10'd7, 32'h0000_0000, 4'h5), nop(), 1'b0, 2'b10, 32'd0, 32'd0);
        cycle(ld(10'd7), nop(), 1'b0, 2'b10, 32'hFF00_FF00, 32'd0);
        // contention: alternating grants starting with NET
        cycle(st(10'd1, 32'h0000_0011, 4'hF), nop(), 1'b0, 2'b10, 32'd0, 32'd0);
        cycle(nop(), st(10'd2, 32'h0000_0022, 4'hF), 1'b0, 2'b01, 32'd0, 32'd0);
        for (int i = 0; i < 6; i++)
            cycle(ld(10'd1), ld(10'd2), 1'b0, (i % 2 == 0) ? 2'b10 : 2'b01, 32'h11, 32'h22);
        // local write, immediate network read-after-write
        cycle(nop(), st(10'd9, 32'hCAFE_0001, 4'hF), 1'b0, 2'b01, 32'd0, 32'd0);
        cycle(ld(10'd9), nop(), 1'b0, 2'b10, 32'hCAFE_0001, 32'd0);
        // mask-0 store is accepted but changes nothing
        cycle(st(10'd5, 32'h0000_0000, 4'h0), nop(), 1'b0, 2'b10, 32'd0, 32'd0);
        cycle(ld(10'd5), ld(10'd5), 1'b0, 2'b01, 32'd0, 32'hA5A5_1234);
        cycle(ld(10'd5), nop(), 1'b0, 2'b10, 32'hA5A5_1234, 32'd0);
        idle(1);
        chk("hold_net_data", returning_data_o, 32'hA5A5_1234);
        chk("hold_lcl_data", lcl_rdata_o, 32'hA5A5_1234);
        // reset the cycle after a network load grant
        cycle(ld(10'd1), nop(), 1'b0, 2'b10, 32'h11, 32'd0);
        cycle(ld(10'd1), ld(10'd2), 1'b1, 2'b00, 32'd0, 32'd0);
        #1;
        chk("mid_rst_ret_v", {31'd0, returning_v_o}, 32'd0);
        chk("mid_rst_last", {31'd0, dbg_last_o}, 32'd1);
        cycle(ld(10'd1), ld(10'd2), 1'b1, 2'b00, 32'd0, 32'd0);
        cycle(ld(10'd1), ld(10'd2), 1'b0, 2'b10, 32'h11, 32'd0);
        cycle(ld(10'd1), ld(10'd2), 1'b0, 2'b01, 32'd0, 32'h22);
        idle(1);
        // out-of-range address (1000 with mem_els_p = 1000)
        chk("pre_oob_err", {31'd0, err_o}, 32'd0);
        cycle(st(10'd1000, 32'h1234_5678, 4'hF), nop(), 1'b0, 2'b10, 32'd0, 32'd0);
        cycle(ld(10'd1000), nop(), 1'b0, 2'b10, exp_oob_word, 32'd0);
        idle(1);
        chk("oob_err", {31'd0, err_o}, exp_err);
        cycle(ld(10'd0), nop(), 1'b0, 2'b10, 32'h0000_0A0A, 32'd0);
        idle(3);
        chk("oob_err_sticky", {31'd0, err_o}, exp_err);
        chk("net_q_drained", net_exp_q.size(), 32'd0);
        chk("lcl_q_drained", lcl_exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
